reg_file_2r1w: RTL and testbench



---
 rtl/reg_file_2r1w.sv | 145 ++++++++++++++
 tb/tb_reg_file_2r1w.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// -----------------------------------------------------------------------------
// reg_file_2r1w
//
// General-purpose register bank for the datapath: one write port and two
// independent registered read ports. Each cycle it can return two operands
// and accept one write-back.
//
// Features
//   - write-first bypass: a read of the address being written in the same
//     cycle returns the new data
//   - per-entry "initialised" flag (INIT_V), set by a write and cleared by
//     RST or CLR
//   - synchronous bulk clear (CLR) that takes priority over a same-cycle write
//   - DEPTH need not be a power of two. Out-of-range writes are dropped, and
//     out-of-range reads return 0 / INIT=0 with VALID=1.
//
// Ports
//   CLK                    clock, all logic on the rising edge
//   RST                    synchronous active-high reset; overrides everything
//   CLR                    clear all entries to 0 and mark them uninitialised
//   WR_EN/WR_ADDR/WR_DATA  write port
//   RDx_EN/RDx_ADDR        read request, port x (x = 0, 1)
//   RDx_DATA               registered read data, port x
//   RDx_VALID              RDx_DATA/RDx_INIT were updated at the last edge
//   RDx_INIT               the entry read had been written since the last RST/CLR
//
// Read handshake: there is no back-pressure. A request is taken on every edge
// where RDx_EN=1. One cycle later RDx_VALID=1 for exactly one cycle per
// request. When RDx_EN=0, RDx_VALID drops to 0 and RDx_DATA/RDx_INIT keep
// their last values.
// -----------------------------------------------------------------------------
module reg_file_2r1w #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLR,
    input  logic              WR_EN,
    input  logic [AW-1:0]     WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic              RD0_EN,
    input  logic [AW-1:0]     RD0_ADDR,
    output logic [DATA_W-1:0] RD0_DATA,
    output logic              RD0_VALID,
    output logic              RD0_INIT,
    input  logic              RD1_EN,
    input  logic [AW-1:0]     RD1_ADDR,
    output logic [DATA_W-1:0] RD1_DATA,
    output logic              RD1_VALID,
    output logic              RD1_INIT
);

    // Address limit, one bit wider than an address so that DEPTH itself
    // can be represented even when DEPTH is a power of two.
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  init_v;

    logic wr_in_range;
    logic wr_fire;

    assign wr_in_range = ({1'b0, WR_ADDR} < DEPTH_LIM);
    // CLR wins over a same-cycle write, so the write is lost.
    assign wr_fire     = WR_EN && !CLR && wr_in_range;

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            init_v <= '0;
        end else if (wr_fire) begin
            mem[WR_ADDR]    <= WR_DATA;
            init_v[WR_ADDR] <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Read ports. Both ports use the same structure, so the inputs and
    // outputs are gathered into small arrays and built in a generate loop.
    // -------------------------------------------------------------------------
    logic              rd_en    [2];
    logic [AW-1:0]     rd_addr  [2];
    logic [DATA_W-1:0] rd_data_q[2];
    logic              rd_valid_q[2];
    logic              rd_init_q[2];

    assign rd_en[0]   = RD0_EN;
    assign rd_en[1]   = RD1_EN;
    assign rd_addr[0] = RD0_ADDR;
    assign rd_addr[1] = RD1_ADDR;

    assign RD0_DATA  = rd_data_q[0];
    assign RD0_VALID = rd_valid_q[0];
    assign RD0_INIT  = rd_init_q[0];
    assign RD1_DATA  = rd_data_q[1];
    assign RD1_VALID = rd_valid_q[1];
    assign RD1_INIT  = rd_init_q[1];

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic              rd_in_range;
        logic [DATA_W-1:0] eff_data;
        logic              eff_init;

        assign rd_in_range = ({1'b0, rd_addr[p]} < DEPTH_LIM);

        // Effective contents of the addressed entry as seen by this edge:
        // clear first, then the in-flight write (bypass), then the array.
        always_comb begin
            eff_data = '0;
            eff_init = 1'b0;
            if (CLR) begin
                eff_data = '0;
                eff_init = 1'b0;
            end else if (WR_EN && wr_in_range && (WR_ADDR == rd_addr[p])) begin
                eff_data = WR_DATA;
                eff_init = 1'b1;
            end else if (rd_in_range) begin
                eff_data = mem[rd_addr[p]];
                eff_init = init_v[rd_addr[p]];
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                rd_valid_q[p] <= 1'b0;
                rd_data_q[p]  <= '0;
                rd_init_q[p]  <= 1'b0;
            end else begin
                rd_valid_q[p] <= rd_en[p];
                if (rd_en[p]) begin
                    rd_data_q[p] <= eff_data;
                    rd_init_q[p] <= eff_init;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// -----------------------------------------------------------------------------
// tb_reg_file_2r1w
//
// Two instances are driven from the same inputs:
//   u_d4 : DATA_W=8, DEPTH=4 (addresses use the low 2 bits)
//   u_d5 : DATA_W=8, DEPTH=5 (addresses use all 3 bits)
// The directed table checks u_d4. The hand-written tail checks the
// non-power-of-two behaviour on u_d5.
// -----------------------------------------------------------------------------
module tb_reg_file_2r1w;

    // ---------------------------------------------------------------- clock
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- stimulus
    logic       rst      = 1'b1;
    logic       clr      = 1'b0;
    logic       wr_en    = 1'b0;
    logic [2:0] wr_addr  = '0;
    logic [7:0] wr_data  = '0;
    logic       rd0_en   = 1'b0;
    logic [2:0] rd0_addr = '0;
    logic       rd1_en   = 1'b0;
    logic [2:0] rd1_addr = '0;

    logic [7:0] d4_rd0_data, d4_rd1_data, d5_rd0_data, d5_rd1_data;
    logic       d4_rd0_valid, d4_rd1_valid, d5_rd0_valid, d5_rd1_valid;
    logic       d4_rd0_init, d4_rd1_init, d5_rd0_init, d5_rd1_init;

    reg_file_2r1w #(.DATA_W(8), .DEPTH(4)) u_d4 (
        .CLK(clk), .RST(rst), .CLR(clr),
        .WR_EN(wr_en), .WR_ADDR(wr_addr[1:0]), .WR_DATA(wr_data),
        .RD0_EN(rd0_en), .RD0_ADDR(rd0_addr[1:0]),
        .RD0_DATA(d4_rd0_data), .RD0_VALID(d4_rd0_valid), .RD0_INIT(d4_rd0_init),
        .RD1_EN(rd1_en), .RD1_ADDR(rd1_addr[1:0]),
        .RD1_DATA(d4_rd1_data), .RD1_VALID(d4_rd1_valid), .RD1_INIT(d4_rd1_init)
    );

    reg_file_2r1w #(.DATA_W(8), .DEPTH(5)) u_d5 (
        .CLK(clk), .RST(rst), .CLR(clr),
        .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
        .RD0_EN(rd0_en), .RD0_ADDR(rd0_addr),
        .RD0_DATA(d5_rd0_data), .RD0_VALID(d5_rd0_valid), .RD0_INIT(d5_rd0_init),
        .RD1_EN(rd1_en), .RD1_ADDR(rd1_addr),
        .RD1_DATA(d5_rd1_data), .RD1_VALID(d5_rd1_valid), .RD1_INIT(d5_rd1_init)
    );

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic       rst, clr, wr_en;
        logic [2:0] wr_addr;
        logic [7:0] wr_data;
        logic       rd0_en;
        logic [2:0] rd0_addr;
        logic       rd1_en;
        logic [2:0] rd1_addr;
        // expected outputs after the edge that samples these inputs
        logic       e0_v;
        logic [7:0] e0_d;
        logic       e0_i;
        logic       e1_v;
        logic [7:0] e1_d;
        logic       e1_i;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rs, input logic cl,
        input logic we, input logic [2:0] wa, input logic [7:0] wd,
        input logic r0e, input logic [2:0] r0a,
        input logic r1e, input logic [2:0] r1a,
        input logic e0v, input logic [7:0] e0d, input logic e0i,
        input logic e1v, input logic [7:0] e1d, input logic e1i);
        vec_t v;
        v.rst = rs; v.clr = cl; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
        v.rd0_en = r0e; v.rd0_addr = r0a; v.rd1_en = r1e; v.rd1_addr = r1a;
        v.e0_v = e0v; v.e0_d = e0d; v.e0_i = e0i;
        v.e1_v = e1v; v.e1_d = e1d; v.e1_i = e1i;
        return v;
    endfunction

    // ---------------------------------------------------------------- scoreboard
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- driver
    // Inputs change at the falling edge; outputs are sampled 1 ns after the
    // rising edge that consumed them.
    task automatic drive(input logic rs, input logic cl,
                         input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic r0e, input logic [2:0] r0a,
                         input logic r1e, input logic [2:0] r1a);
        @(negedge clk);
        rst = rs; clr = cl; wr_en = we; wr_addr = wa; wr_data = wd;
        rd0_en = r0e; rd0_addr = r0a; rd1_en = r1e; rd1_addr = r1a;
        @(posedge clk);
        #1;
    endtask

    task automatic check_d5(input string tag,
                            input logic e0v, input logic [7:0] e0d, input logic e0i,
                            input logic e1v, input logic [7:0] e1d, input logic e1i);
        check({tag, " rd0_valid"}, 32'(d5_rd0_valid), 32'(e0v));
        check({tag, " rd0_data"},  32'(d5_rd0_data),  32'(e0d));
        check({tag, " rd0_init"},  32'(d5_rd0_init),  32'(e0i));
        check({tag, " rd1_valid"}, 32'(d5_rd1_valid), 32'(e1v));
        check({tag, " rd1_data"},  32'(d5_rd1_data),  32'(e1d));
        check({tag, " rd1_init"},  32'(d5_rd1_init),  32'(e1i));
    endtask

    // ---------------------------------------------------------------- test
    initial begin
        //               rst clr we wa   wd     r0e r0a  r1e r1a   e0: v  d      i    e1: v  d      i
        // reset for 2 cycles
        tbl.push_back(mk(1, 0, 0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0,  0, 8'h00, 0,  0, 8'h00, 0));
        tbl.push_back(mk(1, 0, 1, 3'd1, 8'hEE, 1, 3'd1, 1, 3'd1,  0, 8'h00, 0,  0, 8'h00, 0));
        // read every entry after reset: 0 / uninitialised
        tbl.push_back(mk(0, 0, 0, 3'd0, 8'h00, 1, 3'd0, 1, 3'd1,  1, 8'h00, 0,  1, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 3'd0, 8'h00, 1, 3'd2, 1, 3'd3,  1, 8'h00, 0,  1, 8'h00, 0));
        // writes A5->2, 3C->3 with no reads
        tbl.push_back(mk(0, 0, 1, 3'd2, 8'hA5, 0, 3'd0, 0, 3'd0,  0, 8'h00, 0,  0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 1, 3'd3, 8'h3C, 0, 3'd0, 0, 3'd0,  0, 8'h00, 0,  0, 8'h00, 0));
        // read them back from the array
        tbl.push_back(mk(0, 0, 0, 3'd0, 8'h00, 1, 3'd2, 1, 3'd3,  1, 8'hA5, 1,  1, 8'h3C, 1));
        tbl.push_back(mk(0, 0, 0, 3'd0, 8'h00, 1, 3'd2, 0, 3'd0,  1, 8'hA5, 1,  0, 8'h3C, 1));
        // hold: RD0 idle for 3 cycles while entry 2 is rewritten to 00
        tbl.push_back(mk(0, 0, 1, 3'd2, 8'h00, 0, 3'd0, 0, 3'd0,  0, 8'hA5, 1,  0, 8'h3C, 1));
        tbl.push_back(mk(0, 0, 0, 3'd0, 8'h00, 0, 3'd0, 1, 3'd2,  0, 8'hA5, 1,  1, 8'h00, 1));
        tbl.push_back(mk(0, 0, 0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0,  0, 8'hA5, 1,  0, 8'h00, 1));
        // bypass: write 77->1 while both ports read 1
        tbl.push_back(mk(0, 0, 1, 3'd1, 8'h77, 1, 3'd1, 1, 3'd1,  1, 8'h77, 1,  1, 8'h77, 1));
        tbl.push_back(mk(0, 0, 0, 3'd0, 8'h00, 1, 3'd1, 1, 3'd0,  1, 8'h77, 1,  1, 8'h00, 0));
        // CLR priority: preload 11->0, then CLR with write FF->0
        tbl.push_back(mk(0, 0, 1, 3'd0, 8'h11, 0, 3'd0, 0, 3'd0,  0, 8'h77, 1,  0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 3'd0, 8'h00, 1, 3'd0, 0, 3'd0,  1, 8'h11, 1,  0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 1, 3'd0, 8'hFF, 1, 3'd0, 1, 3'd3,  1, 8'h00, 0,  1, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 3'd0, 8'h00, 1, 3'd0, 1, 3'd2,  1, 8'h00, 0,  1, 8'h00, 0));
        // CLR held: write to 1 is lost, bypass suppressed
        tbl.push_back(mk(0, 1, 1, 3'd1, 8'h42, 1, 3'd1, 0, 3'd0,  1, 8'h00, 0,  0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 3'd0, 8'h00, 1, 3'd1, 1, 3'd0,  1, 8'h00, 0,  1, 8'h00, 0));
        // bypass on both ports at entry 3
        tbl.push_back(mk(0, 0, 1, 3'd3, 8'h99, 1, 3'd3, 1, 3'd3,  1, 8'h99, 1,  1, 8'h99, 1));
        // reset mid-operation: no VALID, write lost, outputs cleared
        tbl.push_back(mk(1, 0, 1, 3'd2, 8'h12, 1, 3'd3, 1, 3'd3,  0, 8'h00, 0,  0, 8'h00, 0));
        // first read in the cycle reset drops
        tbl.push_back(mk(0, 0, 0, 3'd0, 8'h00, 1, 3'd2, 1, 3'd3,  1, 8'h00, 0,  1, 8'h00, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            drive(v.rst, v.clr, v.wr_en, v.wr_addr, v.wr_data,
                  v.rd0_en, v.rd0_addr, v.rd1_en, v.rd1_addr);
            check($sformatf("v%0d rd0_valid", i), 32'(d4_rd0_valid), 32'(v.e0_v));
            check($sformatf("v%0d rd0_data", i),  32'(d4_rd0_data),  32'(v.e0_d));
            check($sformatf("v%0d rd0_init", i),  32'(d4_rd0_init),  32'(v.e0_i));
            check($sformatf("v%0d rd1_valid", i), 32'(d4_rd1_valid), 32'(v.e1_v));
            check($sformatf("v%0d rd1_data", i),  32'(d4_rd1_data),  32'(v.e1_d));
            check($sformatf("v%0d rd1_init", i),  32'(d4_rd1_init),  32'(v.e1_i));
        end

        // ------------------------------------------------ DEPTH=5 corner cases
        drive(1, 0, 0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0);
        check_d5("d5 reset", 0, 8'h00, 0, 0, 8'h00, 0);
        // out-of-range write to 6 while both ports read 6: no bypass, 0/0
        drive(0, 0, 1, 3'd6, 8'hEE, 1, 3'd6, 1, 3'd6);
        check_d5("d5 oor bypass", 1, 8'h00, 0, 1, 8'h00, 0);
        // 6 still empty; 2 (6 mod 4) must not have been hit
        drive(0, 0, 0, 3'd0, 8'h00, 1, 3'd6, 1, 3'd2);
        check_d5("d5 oor read", 1, 8'h00, 0, 1, 8'h00, 0);
        // top entry 4: write with bypass on RD1, then read back on RD0
        drive(0, 0, 1, 3'd4, 8'h5A, 0, 3'd0, 1, 3'd4);
        check_d5("d5 wr4 bypass", 0, 8'h00, 0, 1, 8'h5A, 1);
        drive(0, 0, 0, 3'd0, 8'h00, 1, 3'd4, 1, 3'd7);
        check_d5("d5 rd4", 1, 8'h5A, 1, 1, 8'h00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
